// File: rtl/uart_word_tx_arbiter_if.sv
// Requester and UART-FIFO side of the word arbiter: level requests with a one-cycle ack,
// plus the byte write strobe/data qualified by the FIFO full flag.
interface uart_word_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req;
    logic [16*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    ack;
    logic                  tx_full;
    logic                  tx_wr;
    logic [7:0]            tx_data;

    modport master (
        output req, req_data, tx_full,
        input  ack, tx_wr, tx_data
    );

    modport slave (
        input  req, req_data, tx_full,
        output ack, tx_wr, tx_data
    );
endinterface

// File: rtl/uart_word_tx_arbiter.sv
// Round-robin arbiter serialising 16-bit words into 4-byte frames (hdr, lo, hi, xor); ack one cycle after grant,
// one byte per cycle when tx_full=0, bytes held indefinitely while tx_full=1.
module uart_word_tx_arbiter #(
    parameter int         NUM_REQ = 4,
    parameter logic [3:0] HDR_TAG = 4'hA
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    uart_word_tx_arbiter_if.slave       bus,
    output logic                        busy,
    output logic                        frame_done,
    output logic [3:0]                  last_id
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR  = 3'd1;
    localparam logic [2:0] ST_LO   = 3'd2;
    localparam logic [2:0] ST_HI   = 3'd3;
    localparam logic [2:0] ST_CHK  = 3'd4;

    logic [2:0]         state;
    logic [2:0]         state_nxt;
    logic [15:0]        word_q;
    logic [3:0]         id_q;
    logic [NUM_REQ-1:0] ack_q;

    logic               grant;
    logic               hi_found;
    logic [3:0]         hi_win;
    logic [3:0]         lo_win;
    logic [3:0]         winner;
    logic [15:0]        win_word;
    logic [NUM_REQ-1:0] win_onehot;

    logic [7:0]         hdr_byte;
    logic               byte_state;

    // Rotating priority: the lowest requester above last_id wins, else wrap to the lowest overall.
    always_comb begin
        hi_found = 1'b0;
        hi_win   = '0;
        lo_win   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                lo_win = 4'(i);
                if (4'(i) > last_id) begin
                    hi_found = 1'b1;
                    hi_win   = 4'(i);
                end
            end
        end
        winner = hi_found ? hi_win : lo_win;
    end

    always_comb begin
        win_word   = '0;
        win_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (4'(i) == winner) begin
                win_word      = bus.req_data[16*i +: 16];
                win_onehot[i] = 1'b1;
            end
        end
    end

    assign grant      = (state == ST_IDLE) && enable && (|bus.req);
    assign byte_state = (state == ST_HDR) || (state == ST_LO) ||
                        (state == ST_HI)  || (state == ST_CHK);
    assign hdr_byte   = {HDR_TAG, id_q};

    assign bus.tx_wr  = byte_state && !bus.tx_full;
    assign bus.ack    = ack_q;
    assign busy       = (state != ST_IDLE);

    always_comb begin
        bus.tx_data = 8'h00;
        case (state)
            ST_HDR:  bus.tx_data = hdr_byte;
            ST_LO:   bus.tx_data = word_q[7:0];
            ST_HI:   bus.tx_data = word_q[15:8];
            ST_CHK:  bus.tx_data = hdr_byte ^ word_q[7:0] ^ word_q[15:8];
            default: bus.tx_data = 8'h00;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (grant)     state_nxt = ST_HDR;
            ST_HDR:  if (bus.tx_wr) state_nxt = ST_LO;
            ST_LO:   if (bus.tx_wr) state_nxt = ST_HI;
            ST_HI:   if (bus.tx_wr) state_nxt = ST_CHK;
            ST_CHK:  if (bus.tx_wr) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            word_q     <= '0;
            id_q       <= '0;
            last_id    <= 4'(NUM_REQ - 1);
            ack_q      <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            ack_q      <= '0;
            frame_done <= (state == ST_CHK) && bus.tx_wr;
            if (grant) begin
                word_q  <= win_word;
                id_q    <= winner;
                last_id <= winner;
                ack_q   <= win_onehot;
            end
        end
    end

endmodule

// File: tb/tb_uart_word_tx_arbiter.sv
// Scoreboard bench: stimulus predicts grant order and frame bytes from round-robin rules; a negedge monitor
// pops and compares every ack and every written byte.
module tb_uart_word_tx_arbiter;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       busy;
    logic       frame_done;
    logic [3:0] last_id;

    always #5 clk = ~clk;

    uart_word_tx_arbiter_if #(.NUM_REQ(N)) bus ();

    uart_word_tx_arbiter #(.NUM_REQ(N), .HDR_TAG(4'hA)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .bus        (bus),
        .busy       (busy),
        .frame_done (frame_done),
        .last_id    (last_id)
    );

    int         n_checks = 0;
    int         n_err = 0;
    logic [7:0] byte_q[$];
    int         id_q[$];
    int         exp_frames = 0;
    int         done_seen = 0;
    int         ack_cnt = 0;
    int         model_last = N - 1;
    bit         hold_req = 0;
    bit         scramble = 0;
    bit         rand_full = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int rr_next(int last, logic [N-1:0] pend);
        for (int k = 1; k <= N; k++)
            if (pend[(last + k) % N]) return (last + k) % N;
        return 0;
    endfunction

    task automatic push_frame(int id, logic [15:0] w);
        logic [7:0] h;
        h = {4'hA, 4'(id)};
        byte_q.push_back(h);
        byte_q.push_back(w[7:0]);
        byte_q.push_back(w[15:8]);
        byte_q.push_back(h ^ w[7:0] ^ w[15:8]);
        id_q.push_back(id);
        exp_frames++;
    endtask

    // Requests in a round are held until acked, so the order is pure rotation over the mask.
    task automatic push_round(logic [N-1:0] mask);
        logic [N-1:0] pend;
        int w;
        pend = mask;
        while (pend != '0) begin
            w = rr_next(model_last, pend);
            push_frame(w, bus.req_data[16*w +: 16]);
            model_last = w;
            pend[w] = 1'b0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        if (bus.ack != '0) begin
            ack_cnt++;
            if (!hold_req) begin
                for (int i = 0; i < N; i++) begin
                    if (bus.ack[i]) begin
                        bus.req[i] = 1'b0;
                        if (scramble) bus.req_data[16*i +: 16] = 16'($urandom);
                    end
                end
            end
        end
        if (rand_full) bus.tx_full = ($urandom_range(0, 2) == 0);
    endtask

    task automatic wait_idle(string name);
        int n;
        n = 0;
        while ((bus.req != '0 || busy || bus.ack != '0) && n < 400) begin
            cycle();
            n++;
        end
        if (n >= 400) begin
            n_checks++;
            n_err++;
            $display("FAIL %s: timeout waiting for idle, req=%0h busy=%0b", name, bus.req, busy);
        end
    endtask

    task automatic wait_not_busy(string name);
        int n;
        n = 0;
        while (busy && n < 100) begin
            cycle();
            n++;
        end
        if (n >= 100) begin
            n_checks++;
            n_err++;
            $display("FAIL %s: timeout waiting for busy=0", name);
        end
    endtask

    // Monitor: every written byte and every ack is matched against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.tx_wr) begin
                if (byte_q.size() == 0) begin
                    check("tx_unexpected", {24'h0, bus.tx_data}, 32'hFFFF_FFFF);
                end else begin
                    automatic logic [7:0] eb = byte_q.pop_front();
                    check("tx_byte", {24'h0, bus.tx_data}, {24'h0, eb});
                end
            end
            if (bus.tx_full) check("wr_while_full", {31'h0, bus.tx_wr}, 32'h0);
            if (!busy) check("wr_while_idle", {31'h0, bus.tx_wr}, 32'h0);
            if (bus.ack != '0) begin
                check("ack_onehot", $countones(bus.ack), 1);
                if (id_q.size() == 0) begin
                    check("ack_unexpected", {28'h0, bus.ack}, 32'h0);
                end else begin
                    automatic int eid = id_q.pop_front();
                    check("ack_id", {28'h0, bus.ack}, 32'(1) << eid);
                    check("last_id", {28'h0, last_id}, 32'(eid));
                end
            end
            if (frame_done) done_seen++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;
        logic [N-1:0] mask;
        int n;

        reset = 1'b1;
        enable = 1'b0;
        bus.req = '0;
        bus.req_data = '0;
        bus.tx_full = 1'b0;
        cycle();
        cycle();
        check("rst_ack", {28'h0, bus.ack}, 32'h0);
        check("rst_tx_wr", {31'h0, bus.tx_wr}, 32'h0);
        check("rst_tx_data", {24'h0, bus.tx_data}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_frame_done", {31'h0, frame_done}, 32'h0);
        check("rst_last_id", {28'h0, last_id}, 32'(N - 1));
        reset = 1'b0;
        model_last = N - 1;

        // Single request: exact latency of ack, bytes and frame_done.
        enable = 1'b1;
        bus.req_data[31:16] = 16'h1234;
        push_round(4'b0010);
        bus.req = 4'b0010;
        cycle();
        check("t1_ack", {28'h0, bus.ack}, 32'h2);
        check("t1_busy", {31'h0, busy}, 32'h1);
        check("t1_hdr_wr", {31'h0, bus.tx_wr}, 32'h1);
        cycle();
        cycle();
        cycle();
        check("t1_chk_byte", {24'h0, bus.tx_data}, 32'h87);
        cycle();
        check("t1_frame_done", {31'h0, frame_done}, 32'h1);
        check("t1_idle", {31'h0, busy}, 32'h0);
        check("t1_last_id", {28'h0, last_id}, 32'h1);
        cycle();
        check("t1_no_reack", {28'h0, bus.ack}, 32'h0);

        // All requests held high from reset: 0,1,2,3,0.
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        model_last = N - 1;
        enable = 1'b1;
        bus.req_data = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
        push_round(4'b1111);
        push_frame(0, 16'h0000);
        model_last = 0;
        hold_req = 1;
        ack_cnt = 0;
        bus.req = 4'b1111;
        n = 0;
        while (ack_cnt < 5 && n < 100) begin
            cycle();
            n++;
        end
        check("rr_ack_count", ack_cnt, 5);
        enable = 1'b0;
        bus.req = '0;
        hold_req = 0;
        wait_idle("rr");
        enable = 1'b1;

        // Backpressure on the LO byte for 10 cycles.
        bus.req_data[63:48] = 16'hBEEF;
        push_round(4'b1000);
        bus.req = 4'b1000;
        cycle();
        check("bp_ack", {28'h0, bus.ack}, 32'h8);
        cycle();
        bus.tx_full = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) cycle();
            #1;
            check("bp_stall_wr", {31'h0, bus.tx_wr}, 32'h0);
            check("bp_stall_data", {24'h0, bus.tx_data}, 32'hEF);
        end
        bus.tx_full = 1'b0;
        wait_idle("bp");

        // enable dropped during HI: frame finishes, then no grant until re-enabled.
        w = 16'($urandom);
        bus.req_data[15:0] = w;
        push_round(4'b0001);
        bus.req = 4'b0001;
        cycle();
        cycle();
        cycle();
        enable = 1'b0;
        bus.req[0] = 1'b1;
        wait_not_busy("en_gate");
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("en_gate_busy", {31'h0, busy}, 32'h0);
            check("en_gate_ack", {28'h0, bus.ack}, 32'h0);
        end
        push_round(4'b0001);
        enable = 1'b1;
        cycle();
        check("en_regrant_ack", {28'h0, bus.ack}, 32'h1);
        wait_idle("en_regrant");

        // Reset in the cycle after the header write abandons the frame.
        byte_q.push_back(8'hA1);
        id_q.push_back(1);
        bus.req_data[31:16] = 16'($urandom);
        bus.req = 4'b0010;
        cycle();
        check("rst_mid_ack", {28'h0, bus.ack}, 32'h2);
        cycle();
        reset = 1'b1;
        #1;
        check("rst_mid_tx_wr", {31'h0, bus.tx_wr}, 32'h0);
        check("rst_mid_busy", {31'h0, busy}, 32'h0);
        check("rst_mid_ack0", {28'h0, bus.ack}, 32'h0);
        check("rst_mid_hdr_only", byte_q.size(), 0);
        cycle();
        reset = 1'b0;
        model_last = N - 1;
        bus.req_data[47:32] = 16'hC0DE;
        push_round(4'b0100);
        bus.req = 4'b0100;
        cycle();
        check("post_rst_ack", {28'h0, bus.ack}, 32'h4);
        check("post_rst_hdr", {24'h0, bus.tx_data}, 32'hA2);
        wait_idle("post_rst");

        // req_data changed during LO must not alter the frame.
        w = 16'($urandom);
        bus.req_data[15:0] = w;
        push_round(4'b0001);
        bus.req = 4'b0001;
        cycle();
        cycle();
        bus.req_data[15:0] = ~w;
        wait_idle("data_change");

        // Random rounds with random backpressure and post-ack data scrambling.
        scramble = 1;
        rand_full = 1;
        for (int r = 0; r < 40; r++) begin
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < N; i++)
                if (mask[i]) bus.req_data[16*i +: 16] = 16'($urandom);
            push_round(mask);
            bus.req = mask;
            wait_idle("random");
        end
        rand_full = 0;
        bus.tx_full = 1'b0;
        cycle();
        cycle();

        check("frames_done", done_seen, exp_frames);
        check("scoreboard_drained", byte_q.size() + id_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_word_tx_arbiter.md
Name: uart_word_tx_arbiter

Overview:
- Shares one byte-wide UART transmit FIFO (write strobe plus full flag) among NUM_REQ producers of 16-bit words.
- Round-robin grant; each granted word goes out as a 4-byte frame: header, low byte, high byte, XOR checksum.
- Sits between the sensor/game-logic word producers and the UART unit on the 100 MHz board clock, replacing ad-hoc per-word byte buffering.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- HDR_TAG, 4'hA, upper nibble of every header byte.

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-high.
- enable  input  1  high permits new grants; low lets the current frame finish, then holds IDLE.
- req  input  NUM_REQ  per-requester word-pending request, level.
- req_data  input  16*NUM_REQ  word of requester i on bits [16i+15:16i]; held stable while req[i]=1 and ack[i]=0.
- ack  output  NUM_REQ  one-cycle pulse; word of that requester latched.
- tx_full  input  1  UART transmit FIFO full.
- tx_wr  output  1  FIFO write strobe; combinational.
- tx_data  output  8  FIFO write byte; combinational.
- busy  output  1  high whenever state is not IDLE.
- frame_done  output  1  one-cycle pulse after the checksum byte is written.
- last_id  output  4  id of the most recent grant.

Behaviour:
- Reset values:
  - state IDLE.
  - ack=0, frame_done=0, tx_wr=0, tx_data=8'h00, busy=0.
  - last_id=NUM_REQ-1, so requester 0 wins first.
  - Latched word and id = 0.
- FSM states: IDLE, HDR, LO, HI, CHK.
- IDLE, when enable=1 and |req:
  - The winner is the first set req bit scanning last_id+1, last_id+2, ... with wrap at NUM_REQ.
  - On the clock edge: latch req_data of the winner and its id, set last_id=winner, set ack[winner]=1 for the next cycle only, go to HDR.
- Requester contract: drop req in the ack cycle. If req is still high on the next grant opportunity, it counts as a new request.
- Byte states HDR, LO, HI, CHK:
  - tx_wr = !tx_full.
  - tx_data = {HDR_TAG, id}, word[7:0], word[15:8], and hdr^lo^hi respectively.
  - Advance to the next state only on a cycle with tx_wr=1. With tx_full=1, hold state, keep tx_data valid, tx_wr=0; stall is unbounded.
- After the CHK write: go to IDLE and set frame_done=1 for the next cycle.
- Latency with tx_full=0:
  - req sampled in IDLE at cycle T.
  - ack high in T+1; header write in T+1, low byte T+2, high byte T+3, checksum T+4.
  - frame_done and IDLE in T+5; earliest next ack in T+6.
- Ignored inputs:
  - req changes during HDR..CHK are ignored.
  - req_data is sampled only at the grant edge; later changes do not affect the frame.
- enable deasserted mid-frame: the frame completes normally; no new grant while enable=0.
- Simultaneous requests: exactly one ack per grant; all others wait. With all req held high, the order is 0,1,2,3,0,...
- Asynchronous reset mid-frame: immediate return to reset values. No further bytes; the partial frame is abandoned, and the receiver resynchronises on HDR_TAG.
- Width rules:
  - id is zero-extended to 4 bits.
  - Checksum is 8-bit XOR with no carry.

Test Plan:
- Single request, tx_full=0: reset, enable=1, req=4'b0010, req_data[31:16]=16'h1234 -> ack=4'b0010 in T+1; tx_wr=1 with bytes A1, 34, 12, 87 on T+1..T+4; frame_done=1 at T+5; last_id=1.
- Round-robin: req=4'b1111 held, words 16'h0000, 16'h1111, 16'h2222, 16'h3333 -> headers A0, A1, A2, A3, A0 in order; never two acks in one cycle.
- Backpressure: tx_full=1 for 10 cycles starting at the LO byte of word 16'hBEEF from requester 3 -> tx_wr=0 and tx_data=EF held for the stall; the stream resumes EF, BE, then checksum A3^EF^BE=F2; frame_done still pulses.
- enable gating: enable dropped during HI -> frame completes; with req=4'b0001 still high, no ack and busy stays 0 until enable=1, then ack next cycle.
- Reset mid-frame: assert reset in the cycle after the header write -> tx_wr=0, busy=0, ack=0 immediately; after release with req=4'b0100, the first grant goes to requester 2 with header A2.
- Data change after grant: modify req_data of the granted requester during LO -> transmitted bytes match the value latched at the grant.
